// File: rtl/pool_window_buffer_pkg.sv
// ---------------------------------------------------------------------------
// pool_window_buffer_pkg
//   Shared pooling geometry definitions. The windowing stage and the
//   downstream max_pool2d both derive their output frame size from the same
//   pool_geom_t description, so the arithmetic lives here exactly once.
//   Contents:
//     pool_geom_t     frame width/height, kernel width/height, stride
//     pool_out_dim    number of window positions along one axis (floor)
//     pool_out_w/h    output frame width/height for a geometry
//     pool_ctr_width  bit width for a counter spanning 0..range-1
// ---------------------------------------------------------------------------
package pool_window_buffer_pkg;

    typedef struct packed {
        int width;
        int height;
        int kernel_w;
        int kernel_h;
        int stride;
    } pool_geom_t;

    // Trailing elements that cannot hold a full window are dropped (floor).
    function automatic int pool_out_dim(input int extent, input int kernel, input int stride);
        return (extent - kernel) / stride + 1;
    endfunction

    function automatic int pool_out_w(input pool_geom_t geom);
        return pool_out_dim(geom.width, geom.kernel_w, geom.stride);
    endfunction

    function automatic int pool_out_h(input pool_geom_t geom);
        return pool_out_dim(geom.height, geom.kernel_h, geom.stride);
    endfunction

    // A range of 1 still needs a one-bit register to keep the code uniform.
    function automatic int pool_ctr_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/pool_window_buffer_pos_counter.sv
// ---------------------------------------------------------------------------
// pool_pos_counter
//   Tracks the raster position (col,row) of the beat currently offered to
//   the window buffer, plus stride phase counters, and decodes whether
//   accepting that beat completes a pooling window.
//   Ports:
//     clk           clock, rising edge
//     rst           asynchronous, active-low reset
//     advance       an input beat is accepted this cycle
//     window_fire   accepting the current beat completes a window
//     window_last   that window is the last one of the frame
// ---------------------------------------------------------------------------
module pool_pos_counter
    import pool_window_buffer_pkg::*;
#(
    parameter int FRAME_W  = 4,
    parameter int FRAME_H  = 4,
    parameter int KERNEL_W = 2,
    parameter int KERNEL_H = 2,
    parameter int STRIDE   = 2,
    parameter int OUT_W    = 2,
    parameter int OUT_H    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic advance,
    output logic window_fire,
    output logic window_last
);

    localparam int CW = pool_ctr_width(FRAME_W);
    localparam int RW = pool_ctr_width(FRAME_H);
    localparam int PW = pool_ctr_width(STRIDE);

    localparam logic [CW-1:0] COL_MAX   = CW'(FRAME_W - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_W - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(KERNEL_W - 1 + STRIDE * (OUT_W - 1));
    localparam logic [RW-1:0] ROW_MAX   = RW'(FRAME_H - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL_H - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(KERNEL_H - 1 + STRIDE * (OUT_H - 1));
    localparam logic [PW-1:0] PH_MAX    = PW'(STRIDE - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [PW-1:0] cph;
    logic [PW-1:0] rph;
    logic          col_wrap;
    logic          row_wrap;

    assign col_wrap = (col == COL_MAX);
    assign row_wrap = (row == ROW_MAX);

    // Column position and its stride phase. The phase only starts counting
    // once a full kernel width has been seen on the row, so phase 0 lines up
    // with the right-hand column of every stride-aligned window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            cph <= '0;
        end else if (advance) begin
            if (col_wrap) begin
                col <= '0;
                cph <= '0;
            end else begin
                col <= col + 1'b1;
                if (col >= COL_FIRST) begin
                    cph <= (cph == PH_MAX) ? '0 : cph + 1'b1;
                end else begin
                    cph <= '0;
                end
            end
        end
    end

    // Row position and its stride phase move only when a row completes.
    // Wrapping from the final row lets the next frame follow with no gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            rph <= '0;
        end else if (advance && col_wrap) begin
            if (row_wrap) begin
                row <= '0;
                rph <= '0;
            end else begin
                row <= row + 1'b1;
                if (row >= ROW_FIRST) begin
                    rph <= (rph == PH_MAX) ? '0 : rph + 1'b1;
                end else begin
                    rph <= '0;
                end
            end
        end
    end

    // The current beat is the bottom-right corner of a window when both axes
    // have a full kernel behind them and both phases are stride-aligned.
    always_comb begin
        window_fire = (col >= COL_FIRST) && (row >= ROW_FIRST) &&
                      (cph == '0) && (rph == '0);
        window_last = window_fire && (col == COL_LAST) && (row == ROW_LAST);
    end

endmodule

// File: rtl/pool_window_buffer.sv
// ---------------------------------------------------------------------------
// pool_window_buffer
//   Streaming sliding-window stage feeding max_pool2d. Takes one element per
//   beat in raster order and emits each KERNEL_HEIGHT x KERNEL_WIDTH window at
//   stride positions as a row-major vector, one window per output beat. Only
//   (KERNEL_HEIGHT-1) rows plus KERNEL_WIDTH elements are stored.
//   Ports:
//     clk               clock, rising edge
//     rst               asynchronous, active-low reset
//     data_in_0         one input element
//     data_in_0_valid   input beat valid
//     data_in_0_ready   input beat accepted when valid && ready
//     data_out_0        window, element m*KW+n = kernel row m, column n
//     data_out_0_valid  window valid
//     data_out_0_ready  downstream accepts window
//     data_out_0_last   last window of the frame
// ---------------------------------------------------------------------------
module pool_window_buffer
    import pool_window_buffer_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0 = 8,
    parameter int DATA_IN_0_PRECISION_1 = 3,
    parameter int DATA_IN_0_WIDTH       = 4,
    parameter int DATA_IN_0_HEIGHT      = 4,
    parameter int KERNEL_WIDTH          = 2,
    parameter int KERNEL_HEIGHT         = 2,
    parameter int STRIDE                = 2
) (
    input  logic                                                         clk,
    input  logic                                                         rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]                             data_in_0,
    input  logic                                                         data_in_0_valid,
    output logic                                                         data_in_0_ready,
    output logic [KERNEL_WIDTH*KERNEL_HEIGHT-1:0][DATA_IN_0_PRECISION_0-1:0] data_out_0,
    output logic                                                         data_out_0_valid,
    input  logic                                                         data_out_0_ready,
    output logic                                                         data_out_0_last
);

    localparam pool_geom_t GEOM = '{
        width:    DATA_IN_0_WIDTH,
        height:   DATA_IN_0_HEIGHT,
        kernel_w: KERNEL_WIDTH,
        kernel_h: KERNEL_HEIGHT,
        stride:   STRIDE
    };

    localparam int OUT_W    = pool_out_w(GEOM);
    localparam int OUT_H    = pool_out_h(GEOM);
    localparam int SR_DEPTH = (KERNEL_HEIGHT - 1) * DATA_IN_0_WIDTH + KERNEL_WIDTH;
    localparam int N_ELEM   = KERNEL_WIDTH * KERNEL_HEIGHT;

    // Padding is not supported; a geometry that cannot hold one window, or a
    // fixed-point format with more fraction bits than bits, is rejected.
    generate
        if (DATA_IN_0_WIDTH < KERNEL_WIDTH || DATA_IN_0_HEIGHT < KERNEL_HEIGHT ||
            KERNEL_WIDTH < 1 || KERNEL_HEIGHT < 1 || STRIDE < 1 ||
            DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0) begin : g_bad_geometry
            $error("pool_window_buffer: unsupported geometry or precision");
        end
    endgenerate

    logic [DATA_IN_0_PRECISION_0-1:0] sr [SR_DEPTH];
    logic [N_ELEM-1:0][DATA_IN_0_PRECISION_0-1:0] window;
    logic in_accept;
    logic window_fire;
    logic window_last;
    logic fire_now;

    // The output register is only one deep, so new input is taken only when
    // that register is empty or being drained in the same cycle.
    assign data_in_0_ready = rst && (!data_out_0_valid || data_out_0_ready);
    assign in_accept       = data_in_0_valid && data_in_0_ready;
    assign fire_now        = in_accept && window_fire;

    pool_pos_counter #(
        .FRAME_W  (DATA_IN_0_WIDTH),
        .FRAME_H  (DATA_IN_0_HEIGHT),
        .KERNEL_W (KERNEL_WIDTH),
        .KERNEL_H (KERNEL_HEIGHT),
        .STRIDE   (STRIDE),
        .OUT_W    (OUT_W),
        .OUT_H    (OUT_H)
    ) u_pos_counter (
        .clk         (clk),
        .rst         (rst),
        .advance     (in_accept),
        .window_fire (window_fire),
        .window_last (window_last)
    );

    // Line buffer: sr[0] is the most recent accepted element, so the element
    // k beats older than the incoming one sits at sr[k-1].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SR_DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else if (in_accept) begin
            sr[0] <= data_in_0;
            for (int i = 1; i < SR_DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    // Window tap map. Element (m,n) lies (KH-1-m) rows and (KW-1-n) columns
    // before the incoming bottom-right element; the bottom-right itself is
    // the incoming beat and has not reached the line buffer yet.
    generate
        for (genvar m = 0; m < KERNEL_HEIGHT; m++) begin : g_row
            for (genvar n = 0; n < KERNEL_WIDTH; n++) begin : g_col
                if (m == KERNEL_HEIGHT - 1 && n == KERNEL_WIDTH - 1) begin : g_new
                    assign window[m*KERNEL_WIDTH+n] = data_in_0;
                end else begin : g_tap
                    assign window[m*KERNEL_WIDTH+n] =
                        sr[(KERNEL_HEIGHT-1-m)*DATA_IN_0_WIDTH + (KERNEL_WIDTH-1-n) - 1];
                end
            end
        end
    endgenerate

    // Output register. A fresh window always wins, even when the previous
    // one is being consumed this cycle, which keeps full throughput; while
    // the downstream stalls, window and last are held untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_0_valid <= 1'b0;
            data_out_0_last  <= 1'b0;
            data_out_0       <= '0;
        end else if (fire_now) begin
            data_out_0_valid <= 1'b1;
            data_out_0_last  <= window_last;
            data_out_0       <= window;
        end else if (data_out_0_valid && data_out_0_ready) begin
            data_out_0_valid <= 1'b0;
            data_out_0_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pool_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_pool_window_buffer
//   Drives three pool_window_buffer configurations (4x4 K2 S2, 4x4 K3 S1,
//   5x5 K2 S2) through a shared stream driver. Expected windows are built
//   from frame contents by direct window enumeration and compared with every
//   visible output beat, including the bottom-right beat latency.
// ---------------------------------------------------------------------------
module tb_pool_window_buffer;

    typedef struct packed {
        logic [8:0][7:0] vals;
        logic            last;
        int              br;
    } win_t;

    localparam int G_W  [3] = '{4, 4, 5};
    localparam int G_H  [3] = '{4, 4, 5};
    localparam int G_KW [3] = '{2, 3, 2};
    localparam int G_KH [3] = '{2, 3, 2};
    localparam int G_S  [3] = '{2, 1, 2};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = '0;
    logic       drive_valid = 1'b0;
    logic       out_ready = 1'b1;
    int         sel = 0;
    int         rp_mode = 0;
    logic       manual_ready = 1'b1;

    logic valid_a, valid_b, valid_c;
    logic ready_a, ready_b, ready_c;
    logic ovalid_a, ovalid_b, ovalid_c;
    logic last_a, last_b, last_c;
    logic [3:0][7:0] out_a;
    logic [8:0][7:0] out_b;
    logic [3:0][7:0] out_c;

    logic cur_in_ready, cur_out_valid, cur_out_last;
    int   cur_win [9];

    int tests_run = 0;
    int failures  = 0;

    win_t exp_q [$];
    int   exp_rd = 0;
    int   acc_count = 0;
    int   prev_acc = -1;
    bit   prev_stall = 0;

    assign valid_a = drive_valid && (sel == 0);
    assign valid_b = drive_valid && (sel == 1);
    assign valid_c = drive_valid && (sel == 2);

    pool_window_buffer dut_a (
        .clk(clk), .rst(rst),
        .data_in_0(in_data), .data_in_0_valid(valid_a), .data_in_0_ready(ready_a),
        .data_out_0(out_a), .data_out_0_valid(ovalid_a), .data_out_0_ready(out_ready),
        .data_out_0_last(last_a)
    );

    pool_window_buffer #(.KERNEL_WIDTH(3), .KERNEL_HEIGHT(3), .STRIDE(1)) dut_b (
        .clk(clk), .rst(rst),
        .data_in_0(in_data), .data_in_0_valid(valid_b), .data_in_0_ready(ready_b),
        .data_out_0(out_b), .data_out_0_valid(ovalid_b), .data_out_0_ready(out_ready),
        .data_out_0_last(last_b)
    );

    pool_window_buffer #(.DATA_IN_0_WIDTH(5), .DATA_IN_0_HEIGHT(5)) dut_c (
        .clk(clk), .rst(rst),
        .data_in_0(in_data), .data_in_0_valid(valid_c), .data_in_0_ready(ready_c),
        .data_out_0(out_c), .data_out_0_valid(ovalid_c), .data_out_0_ready(out_ready),
        .data_out_0_last(last_c)
    );

    always #5 clk = ~clk;

    // Route the selected configuration onto one set of observation signals.
    always_comb begin
        cur_in_ready  = 1'b0;
        cur_out_valid = 1'b0;
        cur_out_last  = 1'b0;
        for (int i = 0; i < 9; i++) cur_win[i] = 0;
        case (sel)
            0: begin
                cur_in_ready = ready_a; cur_out_valid = ovalid_a; cur_out_last = last_a;
                for (int i = 0; i < 4; i++) cur_win[i] = int'(out_a[i]);
            end
            1: begin
                cur_in_ready = ready_b; cur_out_valid = ovalid_b; cur_out_last = last_b;
                for (int i = 0; i < 9; i++) cur_win[i] = int'(out_b[i]);
            end
            default: begin
                cur_in_ready = ready_c; cur_out_valid = ovalid_c; cur_out_last = last_c;
                for (int i = 0; i < 4; i++) cur_win[i] = int'(out_c[i]);
            end
        endcase
    end

    // Downstream ready: always on, random, or manually held.
    always @(posedge clk) begin
        #1;
        case (rp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = manual_ready;
        endcase
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Monitor: every visible window is compared with the oldest outstanding
    // expectation; a window that has just appeared must follow the beat that
    // completed it by exactly one cycle.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 0;
            prev_acc   = -1;
            acc_count  = 0;
            exp_rd     = exp_q.size();
        end else begin
            if (cur_out_valid) begin
                if (exp_rd >= exp_q.size()) begin
                    checkOutput("spurious_valid", int'(cur_out_valid), 0);
                end else begin
                    if (!prev_stall) checkOutput("latency_br_beat", prev_acc, exp_q[exp_rd].br);
                    for (int i = 0; i < G_KW[sel] * G_KH[sel]; i++) begin
                        checkOutput($sformatf("win_elem[%0d]", i), cur_win[i],
                                    int'(exp_q[exp_rd].vals[i]));
                    end
                    checkOutput("last_flag", int'(cur_out_last), int'(exp_q[exp_rd].last));
                    if (out_ready) exp_rd++;
                    else checkOutput("in_ready_during_stall", int'(cur_in_ready), 0);
                end
            end
            prev_stall = cur_out_valid && !out_ready;
            if (drive_valid && cur_in_ready) begin
                prev_acc = acc_count;
                acc_count++;
            end else begin
                prev_acc = -1;
            end
        end
    end

    // Reference: enumerate stride-aligned window origins per frame directly.
    task automatic buildExpected(input int vals[$]);
        int w, h, kw, kh, s, frames;
        win_t item;
        w = G_W[sel]; h = G_H[sel]; kw = G_KW[sel]; kh = G_KH[sel]; s = G_S[sel];
        frames = vals.size() / (w * h);
        for (int f = 0; f < frames; f++) begin
            for (int r0 = 0; r0 + kh <= h; r0 += s) begin
                for (int c0 = 0; c0 + kw <= w; c0 += s) begin
                    item = '0;
                    for (int m = 0; m < kh; m++)
                        for (int n = 0; n < kw; n++)
                            item.vals[m*kw+n] = 8'(vals[f*w*h + (r0+m)*w + c0 + n]);
                    item.last = (r0 + s + kh > h) && (c0 + s + kw > w);
                    item.br   = f*w*h + (r0+kh-1)*w + c0 + kw - 1;
                    exp_q.push_back(item);
                end
            end
        end
    endtask

    task automatic driveBeats(input int vals[$], input int gap_max);
        int waited;
        foreach (vals[k]) begin
            if (gap_max > 0) begin
                drive_valid = 1'b0;
                repeat ($urandom_range(0, gap_max)) @(posedge clk);
                #1;
            end
            in_data     = 8'(vals[k]);
            drive_valid = 1'b1;
            waited      = 0;
            forever begin
                @(negedge clk);
                if (cur_in_ready) begin
                    @(posedge clk);
                    #1;
                    break;
                end
                waited++;
                if (waited > 500) begin
                    checkOutput("accept_timeout", waited, 0);
                    break;
                end
            end
        end
        drive_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int vals[$], input int gap_max);
        buildExpected(vals);
        driveBeats(vals, gap_max);
    endtask

    task automatic drainAndCheck(input string tag);
        for (int k = 0; k < 400 && exp_rd < exp_q.size(); k++) @(negedge clk);
        checkOutput({tag, "_windows_left"}, exp_q.size() - exp_rd, 0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid_idle"}, int'(cur_out_valid), 0);
    endtask

    task automatic resetDut(input int new_sel);
        rst         = 1'b0;
        drive_valid = 1'b0;
        sel         = new_sel;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", int'(cur_out_valid), 0);
        checkOutput("reset_out_last", int'(cur_out_last), 0);
        checkOutput("reset_in_ready", int'(cur_in_ready), 0);
        checkOutput("reset_win0", cur_win[0], 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic void rampQueue(ref int q[$], input int base, input int count);
        for (int i = 0; i < count; i++) q.push_back(base + i);
    endfunction

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int seq [$];
        int part [$];
        int waited;

        // 4x4, 2x2 kernel, stride 2, ramp input.
        resetDut(0);
        seq = {}; rampQueue(seq, 0, 16);
        applyStimulus(seq, 0);
        drainAndCheck("t1");

        // 4x4, 3x3 kernel, stride 1.
        resetDut(1);
        applyStimulus(seq, 0);
        drainAndCheck("t2");

        // 5x5, trailing column and row never emitted.
        resetDut(2);
        seq = {}; rampQueue(seq, 0, 25);
        applyStimulus(seq, 0);
        drainAndCheck("t3");

        // Downstream stall for 10 cycles after the first window.
        resetDut(0);
        rp_mode = 2; manual_ready = 1'b0;
        @(posedge clk); #2;
        seq = {}; rampQueue(seq, 0, 16);
        fork
            applyStimulus(seq, 0);
            begin
                waited = 0;
                while (!cur_out_valid && waited < 200) begin
                    @(negedge clk);
                    waited++;
                end
                checkOutput("t4_first_window_seen", int'(cur_out_valid), 1);
                repeat (10) @(negedge clk);
                manual_ready = 1'b1;
            end
        join
        drainAndCheck("t4");
        rp_mode = 0;

        // Two frames back to back.
        resetDut(0);
        seq = {}; rampQueue(seq, 0, 16); rampQueue(seq, 100, 16);
        applyStimulus(seq, 0);
        drainAndCheck("t5");

        // Reset with a window pending, then replay a clean frame.
        resetDut(0);
        part = {}; rampQueue(part, 0, 6);
        driveBeats(part, 0);
        checkOutput("t6_pending_valid", int'(cur_out_valid), 1);
        rst = 1'b0;
        #1;
        checkOutput("t6_reset_valid", int'(cur_out_valid), 0);
        checkOutput("t6_reset_in_ready", int'(cur_in_ready), 0);
        for (int i = 0; i < 4; i++) checkOutput("t6_reset_win", cur_win[i], 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        seq = {}; rampQueue(seq, 0, 16);
        applyStimulus(seq, 0);
        drainAndCheck("t6");

        // Random data, random input gaps, random downstream backpressure.
        for (int c = 0; c < 3; c++) begin
            resetDut(c);
            rp_mode = 1;
            seq = {};
            for (int i = 0; i < 2 * G_W[c] * G_H[c]; i++) seq.push_back(int'($urandom_range(0, 255)));
            applyStimulus(seq, 2);
            drainAndCheck("rand");
            rp_mode = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
